// File: rtl/ide_pkg.sv
// Shared types and task-file constants for the IDE host initiator.
package ide_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LBA0,
        S_LBA1,
        S_LBA2,
        S_CNT,
        S_CMD,
        S_POLL,
        S_XFER,
        S_DONE,
        S_ERROR
    } t_ide_host_state;

    typedef enum logic [1:0] {
        B_IDLE,
        B_SETUP,
        B_STROBE
    } t_bus_state;

    localparam logic [2:0] REG_DATA     = 3'd0;
    localparam logic [2:0] REG_SECCNT   = 3'd2;
    localparam logic [2:0] REG_LBA0     = 3'd3;
    localparam logic [2:0] REG_LBA1     = 3'd4;
    localparam logic [2:0] REG_LBA2     = 3'd5;
    localparam logic [2:0] REG_CMD_STAT = 3'd7;

    localparam int STAT_BSY = 7;
    localparam int STAT_DRQ = 3;
    localparam int STAT_ERR = 0;

    localparam logic [7:0] DEF_CMD_READ  = 8'h20;
    localparam logic [7:0] DEF_CMD_WRITE = 8'h30;

endpackage

// File: rtl/ide_bus_cycle.sv
// Two-clock IDE register access engine: SETUP (ce_n low) then STROBE.
// A start during STROBE chains straight into the next SETUP.
module ide_bus_cycle
    import ide_pkg::*;
(
    input  logic       clk,
    input  logic       arst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [2:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       ack,
    output logic       ide_ce_n,
    output logic       ide_oe_n,
    output logic       ide_we_n,
    output logic [2:0] ide_addr,
    output logic [7:0] ide_wdata,
    output logic       ide_wdata_oe,
    input  logic [7:0] ide_rdata
);

    t_bus_state state;
    t_bus_state state_n;
    logic       rw_q;
    logic [2:0] addr_q;
    logic [7:0] wdata_q;
    logic       load;

    assign load = start && (state != B_SETUP);

    always_comb begin
        state_n = state;
        unique case (state)
            B_IDLE:   if (start) state_n = B_SETUP;
            B_SETUP:  state_n = B_STROBE;
            B_STROBE: state_n = start ? B_SETUP : B_IDLE;
            default:  state_n = B_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state   <= B_IDLE;
            rw_q    <= 1'b0;
            addr_q  <= 3'd0;
            wdata_q <= 8'h00;
        end else begin
            state <= state_n;
            if (load) begin
                rw_q    <= rw;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    // The owner captures rdata on the edge that closes STROBE.
    assign ack          = (state == B_STROBE);
    assign rdata        = ide_rdata;
    assign ide_ce_n     = (state == B_IDLE);
    assign ide_oe_n     = !((state == B_STROBE) && !rw_q);
    assign ide_we_n     = !((state == B_STROBE) && rw_q);
    assign ide_addr     = addr_q;
    assign ide_wdata    = wdata_q;
    assign ide_wdata_oe = rw_q && (state != B_IDLE);

endmodule

// File: rtl/ide_host_ctrl.sv
// Host-side IDE initiator: programs LBA/count/command, polls status,
// then streams one sector through the data register.
module ide_host_ctrl
    import ide_pkg::*;
#(
    parameter int          SECTOR_BYTES = 512,
    parameter logic [15:0] POLL_TIMEOUT = 16'hFFFF,
    parameter logic [7:0]  CMD_READ     = DEF_CMD_READ,
    parameter logic [7:0]  CMD_WRITE    = DEF_CMD_WRITE
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [23:0] req_lba,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        done,
    output logic        error,
    output logic        ide_ce_n,
    output logic        ide_oe_n,
    output logic        ide_we_n,
    output logic [2:0]  ide_addr,
    output logic [7:0]  ide_wdata,
    output logic        ide_wdata_oe,
    input  logic [7:0]  ide_rdata
);

    localparam int CW = $clog2(SECTOR_BYTES) + 1;
    localparam logic [CW-1:0] LAST = CW'(SECTOR_BYTES);

    t_ide_host_state state;
    t_ide_host_state state_n;
    t_ide_host_state target;

    logic          write_q;
    logic [23:0]   lba_q;
    logic [15:0]   poll_cnt;
    logic [CW-1:0] byte_cnt;
    logic [CW-1:0] cnt_eff;
    logic          issued;
    logic          accept;
    logic          xfer_ack;
    logic          poll_last;
    logic          need;
    logic          start;
    logic          bus_rw;
    logic [2:0]    bus_addr;
    logic [7:0]    bus_wdata;
    logic [7:0]    bus_rdata;
    logic          ack;

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign xfer_ack  = ack && (state == S_XFER);
    assign cnt_eff   = byte_cnt + {{(CW-1){1'b0}}, xfer_ack};
    assign poll_last = (POLL_TIMEOUT != 16'd0) &&
                       (({1'b0, poll_cnt} + 17'd1) == {1'b0, POLL_TIMEOUT});

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: if (req_valid) state_n = S_LBA0;
            S_LBA0: if (ack) state_n = S_LBA1;
            S_LBA1: if (ack) state_n = S_LBA2;
            S_LBA2: if (ack) state_n = S_CNT;
            S_CNT:  if (ack) state_n = S_CMD;
            S_CMD:  if (ack) state_n = S_POLL;
            S_POLL: begin
                if (ack) begin
                    if (!bus_rdata[STAT_BSY] && bus_rdata[STAT_ERR])
                        state_n = S_ERROR;
                    else if (!bus_rdata[STAT_BSY] && bus_rdata[STAT_DRQ])
                        state_n = S_XFER;
                    else if (poll_last)
                        state_n = S_ERROR;
                end
            end
            S_XFER: begin
                if (write_q) begin
                    if (xfer_ack && cnt_eff == LAST) state_n = S_DONE;
                end else if (rd_valid && rd_ready && byte_cnt == LAST) begin
                    state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            S_ERROR: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Issue the access for the state we are about to be in, so that
    // consecutive accesses chain without an idle bus cycle.
    assign target = ack ? state_n : state;

    always_comb begin
        need      = 1'b0;
        bus_rw    = 1'b1;
        bus_addr  = REG_DATA;
        bus_wdata = 8'h00;
        unique case (target)
            S_LBA0: begin
                need = 1'b1; bus_addr = REG_LBA0; bus_wdata = lba_q[7:0];
            end
            S_LBA1: begin
                need = 1'b1; bus_addr = REG_LBA1; bus_wdata = lba_q[15:8];
            end
            S_LBA2: begin
                need = 1'b1; bus_addr = REG_LBA2; bus_wdata = lba_q[23:16];
            end
            S_CNT: begin
                need = 1'b1; bus_addr = REG_SECCNT; bus_wdata = 8'h01;
            end
            S_CMD: begin
                need      = 1'b1;
                bus_addr  = REG_CMD_STAT;
                bus_wdata = write_q ? CMD_WRITE : CMD_READ;
            end
            S_POLL: begin
                need = 1'b1; bus_rw = 1'b0; bus_addr = REG_CMD_STAT;
            end
            S_XFER: begin
                bus_rw    = write_q;
                bus_wdata = wr_data;
                if (cnt_eff < LAST) begin
                    if (write_q) need = wr_valid;
                    else need = (!rd_valid || rd_ready) && !xfer_ack;
                end
            end
            default: need = 1'b0;
        endcase
    end

    assign start    = need && (ack || !issued);
    assign wr_ready = start && (target == S_XFER) && write_q;
    assign done     = (state == S_DONE);
    assign error    = (state == S_ERROR);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= S_IDLE;
            write_q  <= 1'b0;
            lba_q    <= 24'd0;
            poll_cnt <= 16'd0;
            byte_cnt <= '0;
            issued   <= 1'b0;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                write_q  <= req_write;
                lba_q    <= req_lba;
                poll_cnt <= 16'd0;
                byte_cnt <= '0;
            end
            if (ack && state == S_POLL) poll_cnt <= poll_cnt + 16'd1;
            if (xfer_ack) byte_cnt <= cnt_eff;
            if (start) issued <= 1'b1;
            else if (ack) issued <= 1'b0;
            if (xfer_ack && !write_q) begin
                rd_data  <= bus_rdata;
                rd_valid <= 1'b1;
            end else if (rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

    ide_bus_cycle u_bus (
        .clk          (clk),
        .arst_n       (arst_n),
        .start        (start),
        .rw           (bus_rw),
        .addr         (bus_addr),
        .wdata        (bus_wdata),
        .rdata        (bus_rdata),
        .ack          (ack),
        .ide_ce_n     (ide_ce_n),
        .ide_oe_n     (ide_oe_n),
        .ide_we_n     (ide_we_n),
        .ide_addr     (ide_addr),
        .ide_wdata    (ide_wdata),
        .ide_wdata_oe (ide_wdata_oe),
        .ide_rdata    (ide_rdata)
    );

endmodule

// File: tb/tb_ide_host_ctrl.sv
// Directed bench for ide_host_ctrl against a small task-file drive model.
module tb_ide_host_ctrl;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [23:0] req_lba = 24'd0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic        done;
    logic        error;
    logic        ide_ce_n;
    logic        ide_oe_n;
    logic        ide_we_n;
    logic [2:0]  ide_addr;
    logic [7:0]  ide_wdata;
    logic        ide_wdata_oe;
    logic [7:0]  ide_rdata;

    int checks = 0;
    int errors = 0;

    ide_host_ctrl #(.POLL_TIMEOUT(16'd8)) dut (
        .clk(clk), .arst_n(arst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_lba(req_lba),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .done(done), .error(error),
        .ide_ce_n(ide_ce_n), .ide_oe_n(ide_oe_n), .ide_we_n(ide_we_n),
        .ide_addr(ide_addr), .ide_wdata(ide_wdata),
        .ide_wdata_oe(ide_wdata_oe), .ide_rdata(ide_rdata)
    );

    always #5 clk = ~clk;

    // Drive model: sector data mem[i] = i+1, scripted status register.
    logic       model_clr = 1'b0;
    int         busy_polls = 2;
    logic [7:0] stat_final = 8'h08;
    int         poll_reads = 0;
    int         rptr = 0;
    int         wn = 0;
    int         wdn = 0;
    int         both_low = 0;
    logic [2:0] wlog_a [0:15];
    logic [7:0] wlog_d [0:15];
    logic [7:0] wmem [0:511];

    always @(posedge clk) begin
        if (model_clr) begin
            poll_reads <= 0;
            rptr <= 0;
            wn <= 0;
            wdn <= 0;
        end else if (!ide_ce_n) begin
            if (!ide_we_n) begin
                if (ide_addr == 3'd0) begin
                    if (wdn < 512) wmem[wdn] <= ide_wdata;
                    wdn <= wdn + 1;
                end else begin
                    if (wn < 16) begin
                        wlog_a[wn] <= ide_addr;
                        wlog_d[wn] <= ide_wdata;
                    end
                    wn <= wn + 1;
                end
            end
            if (!ide_oe_n) begin
                if (ide_addr == 3'd7) poll_reads <= poll_reads + 1;
                else if (ide_addr == 3'd0) rptr <= rptr + 1;
            end
            if (!ide_oe_n && !ide_we_n) both_low <= both_low + 1;
        end
    end

    always_comb begin
        ide_rdata = 8'h00;
        if (ide_addr == 3'd7)
            ide_rdata = (poll_reads < busy_polls) ? 8'h80 : stat_final;
        else if (ide_addr == 3'd0)
            ide_rdata = 8'(rptr + 1);
    end

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 7 + 3);
    endfunction

    logic [7:0] rx [$];
    int done_cnt, err_cnt, stall_bad, widx;
    logic timed_out;

    task automatic run_xfer(input logic w, input logic [23:0] lba,
                            input int stall_at, input int abort_at,
                            input int budget);
        logic w_hs;
        logic fin;
        logic have_held;
        logic [7:0] held;
        int stall_left;
        rx.delete();
        done_cnt = 0; err_cnt = 0; stall_bad = 0; widx = 0;
        @(posedge clk); #1 model_clr = 1'b1;
        @(posedge clk); #1 model_clr = 1'b0;
        rd_ready = 1'b1;
        wr_valid = w;
        wr_data = pat(0);
        req_valid = 1'b1; req_write = w; req_lba = lba;
        @(posedge clk); #1 req_valid = 1'b0;
        fin = 1'b0; have_held = 1'b0; stall_left = 20; timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (error) err_cnt++;
            if (rd_valid && rd_ready) rx.push_back(rd_data);
            w_hs = wr_ready;
            if (!rd_ready && rd_valid) begin
                if (!have_held) begin
                    held = rd_data; have_held = 1'b1;
                end else if (rd_data !== held) stall_bad++;
                if (!ide_ce_n) stall_bad++;
            end
            fin = done || error || (abort_at >= 0 && rx.size() == abort_at);
            @(posedge clk); #1;
            if (w_hs) begin
                widx++; wr_data = pat(widx);
            end
            req_valid = 1'b0;
            if (stall_at >= 0 && rx.size() == stall_at && stall_left > 0) begin
                if (stall_left == 20) begin
                    req_valid = 1'b1; req_write = ~w;
                end
                rd_ready = 1'b0;
                stall_left--;
            end else begin
                rd_ready = 1'b1;
            end
            if (fin) begin
                timed_out = 1'b0;
                break;
            end
        end
        wr_valid = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ide_ce_n, ide_oe_n, ide_we_n, ide_wdata_oe} !== 4'b1110) begin
            errors++;
            $display("FAIL reset_strobes got %b want 1110",
                     {ide_ce_n, ide_oe_n, ide_we_n, ide_wdata_oe});
        end
        checks++;
        if ({req_ready, rd_valid, wr_ready, done, error} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 10000",
                     {req_ready, rd_valid, wr_ready, done, error});
        end
        checks++;
        if ({ide_addr, ide_wdata} !== 11'd0) begin
            errors++;
            $display("FAIL reset_bus got %h/%h want 0/00", ide_addr, ide_wdata);
        end
        arst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || ide_ce_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got rdy=%b ce_n=%b want 1/1",
                     req_ready, ide_ce_n);
        end
    endtask

    task automatic check_setup(input string nm, input logic [7:0] l0,
                               input logic [7:0] l1, input logic [7:0] l2,
                               input logic [7:0] cmd);
        logic [2:0] ea [5];
        logic [7:0] ed [5];
        ea = '{3'd3, 3'd4, 3'd5, 3'd2, 3'd7};
        ed = '{l0, l1, l2, 8'h01, cmd};
        checks++;
        if (wn !== 5) begin
            errors++;
            $display("FAIL %s_setup_count got %0d want 5", nm, wn);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (wlog_a[i] !== ea[i] || wlog_d[i] !== ed[i]) begin
                errors++;
                $display("FAIL %s_setup%0d got reg%0d=%h want reg%0d=%h",
                         nm, i, wlog_a[i], wlog_d[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic check_read_stream(input string nm);
        checks++;
        if (rx.size() != 512) begin
            errors++;
            $display("FAIL %s_count got %0d want 512", nm, rx.size());
        end
        for (int i = 0; i < 512 && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== 8'(i + 1)) begin
                errors++;
                $display("FAIL %s_byte%0d got %h want %h", nm, i, rx[i], 8'(i + 1));
            end
        end
        checks++;
        if (done_cnt !== 1 || err_cnt !== 0 || timed_out !== 1'b0) begin
            errors++;
            $display("FAIL %s_end got done=%0d err=%0d to=%b want 1/0/0",
                     nm, done_cnt, err_cnt, timed_out);
        end
        checks++;
        if (rptr !== 512) begin
            errors++;
            $display("FAIL %s_reg0_reads got %0d want 512", nm, rptr);
        end
    endtask

    task automatic test_read();
        busy_polls = 2; stat_final = 8'h08;
        run_xfer(1'b0, 24'h000000, -1, -1, 5000);
        check_setup("read", 8'h00, 8'h00, 8'h00, 8'h20);
        check_read_stream("read");
        checks++;
        if (poll_reads !== 3) begin
            errors++;
            $display("FAIL read_polls got %0d want 3", poll_reads);
        end
    endtask

    task automatic test_stall();
        busy_polls = 0; stat_final = 8'h08;
        run_xfer(1'b0, 24'hABCDEF, 100, -1, 5000);
        check_setup("stall", 8'hEF, 8'hCD, 8'hAB, 8'h20);
        check_read_stream("stall");
        checks++;
        if (stall_bad !== 0) begin
            errors++;
            $display("FAIL stall_hold got %0d glitches want 0", stall_bad);
        end
    endtask

    task automatic test_write();
        busy_polls = 1; stat_final = 8'h08;
        run_xfer(1'b1, 24'h012345, -1, -1, 5000);
        check_setup("write", 8'h45, 8'h23, 8'h01, 8'h30);
        checks++;
        if (wdn !== 512 || done_cnt !== 1 || err_cnt !== 0 || timed_out !== 1'b0) begin
            errors++;
            $display("FAIL write_end got n=%0d done=%0d err=%0d to=%b want 512/1/0/0",
                     wdn, done_cnt, err_cnt, timed_out);
        end
        for (int i = 0; i < 512; i++) begin
            checks++;
            if (wmem[i] !== pat(i)) begin
                errors++;
                $display("FAIL write_byte%0d got %h want %h", i, wmem[i], pat(i));
            end
        end
    endtask

    task automatic test_timeout();
        busy_polls = 1000; stat_final = 8'h08;
        run_xfer(1'b0, 24'h000010, -1, -1, 500);
        checks++;
        if (poll_reads !== 8) begin
            errors++;
            $display("FAIL timeout_polls got %0d want 8", poll_reads);
        end
        checks++;
        if (err_cnt !== 1 || done_cnt !== 0 || rptr !== 0 || timed_out !== 1'b0) begin
            errors++;
            $display("FAIL timeout_end got err=%0d done=%0d rd=%0d to=%b want 1/0/0/0",
                     err_cnt, done_cnt, rptr, timed_out);
        end
    endtask

    task automatic test_status_err();
        busy_polls = 0; stat_final = 8'h01;
        run_xfer(1'b1, 24'h000020, -1, -1, 500);
        checks++;
        if (poll_reads !== 1 || rptr !== 0 || wdn !== 0) begin
            errors++;
            $display("FAIL staterr_bus got polls=%0d rd=%0d wr=%0d want 1/0/0",
                     poll_reads, rptr, wdn);
        end
        checks++;
        if (err_cnt !== 1 || done_cnt !== 0 || timed_out !== 1'b0) begin
            errors++;
            $display("FAIL staterr_end got err=%0d done=%0d to=%b want 1/0/0",
                     err_cnt, done_cnt, timed_out);
        end
    endtask

    task automatic test_reset_mid_xfer();
        busy_polls = 0; stat_final = 8'h08;
        run_xfer(1'b0, 24'h000100, -1, 50, 3000);
        checks++;
        if (timed_out !== 1'b0 || rx.size() != 50) begin
            errors++;
            $display("FAIL abort_reach got n=%0d to=%b want 50/0", rx.size(), timed_out);
        end
        #2 arst_n = 1'b0;
        #1;
        checks++;
        if ({ide_ce_n, ide_oe_n, ide_we_n, ide_wdata_oe} !== 4'b1110) begin
            errors++;
            $display("FAIL abort_strobes got %b want 1110",
                     {ide_ce_n, ide_oe_n, ide_we_n, ide_wdata_oe});
        end
        @(posedge clk); #1;
        checks++;
        if ({req_ready, rd_valid, done, error} !== 4'b1000) begin
            errors++;
            $display("FAIL abort_idle got %b want 1000",
                     {req_ready, rd_valid, done, error});
        end
        @(negedge clk) arst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (ide_ce_n !== 1'b1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_quiet got ce_n=%b rdy=%b want 1/1", ide_ce_n, req_ready);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_stall();
        test_write();
        test_timeout();
        test_status_err();
        test_reset_mid_xfer();
        test_read();
        checks++;
        if (both_low !== 0) begin
            errors++;
            $display("FAIL strobe_overlap got %0d want 0", both_low);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
